// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: fetches ahead of decode into a DEPTH-entry prefetch
// queue, drains through a valid/ready handshake, and flushes on control-flow redirects.
module if_fetch_queue #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter int               ROM_AW   = 6,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       Z,
  input  logic                       J,
  input  logic                       JR,
  input  logic [WIDTH-1:0]           BranchAddr,
  input  logic [WIDTH-1:0]           JumpAddr,
  input  logic [WIDTH-1:0]           JrAddr,
  output logic [ROM_AW-1:0]          rom_addr,
  input  logic [WIDTH-1:0]           rom_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [WIDTH-1:0]           Instruction_if,
  output logic [WIDTH-1:0]           PC,
  output logic [WIDTH-1:0]           NextPC_if,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_fetch_pc;
  logic [WIDTH-1:0] r_pc_q   [DEPTH];
  logic [WIDTH-1:0] r_inst_q [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_redirect;
  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_target;

  // Fixed priority JR > J > Z; several flags may be raised together.
  function automatic logic [WIDTH-1:0] sel_target(
    input logic             jr,
    input logic             j,
    input logic [WIDTH-1:0] jr_addr,
    input logic [WIDTH-1:0] j_addr,
    input logic [WIDTH-1:0] br_addr
  );
    if (jr)     return jr_addr;
    else if (j) return j_addr;
    else        return br_addr;
  endfunction

  assign w_redirect = Z | J | JR;
  assign w_target   = sel_target(JR, J, JrAddr, JumpAddr, BranchAddr);
  assign w_pop      = inst_valid & inst_ready;
  // A pop frees a slot in the same cycle, so a full queue can still accept a fetch.
  assign w_push     = !w_redirect && ((r_count < FULL) || w_pop);

  // Fetch / queue-write stage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]   <= '0;
        r_inst_q[i] <= '0;
      end
    end else if (w_redirect) begin
      r_fetch_pc <= w_target;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
    end else begin
      if (w_push) begin
        r_pc_q[r_wr_ptr]   <= r_fetch_pc;
        r_inst_q[r_wr_ptr] <= rom_data;
        r_wr_ptr           <= r_wr_ptr + PW'(1);
        r_fetch_pc         <= r_fetch_pc + WIDTH'(4);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head presentation to decode
  assign inst_valid     = (r_count != '0);
  assign Instruction_if = r_inst_q[r_rd_ptr];
  assign PC             = r_pc_q[r_rd_ptr];
  assign NextPC_if      = r_pc_q[r_rd_ptr] + WIDTH'(4);
  assign rom_addr       = r_fetch_pc[ROM_AW+1:2];
  assign count          = r_count;

endmodule
